// File: rtl/add32_pkg.sv
// add32_pkg: shared width, FSM state type and the full-adder cell used by
// the sequential 32-bit adder (add32_seq_ctrl / add_slice).
package add32_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] fulladder(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/add_slice.sv
// add_slice: combinational W-bit ripple adder built from full-adder cells.
// Also exports the carry into the slice MSB so the caller can form signed
// overflow on the final slice.
module add_slice
    import add32_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign {c[i+1], s[i]} = fulladder(a[i], b[i], c[i]);
    end

    assign co    = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/add32_seq_ctrl.sv
// add32_seq_ctrl: 32-bit adder that reuses one SLICE_W-bit add_slice over
// N = 32/SLICE_W cycles behind a valid/ready handshake (IDLE -> RUN -> DONE).
// Optional feature macro: ADD32_SEQ_SUB_EN adds a 'sub' input (A - B).
module add32_seq_ctrl
    import add32_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              cin1,
`ifdef ADD32_SEQ_SUB_EN
    input  logic              sub,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sout,
    output logic              cout,
    output logic              ovf,
    output logic              busy
);

    localparam int N     = DATA_W / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    k_q, k_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                c_q, c_d;
    logic                cout_q, cout_d;
    logic                ovf_q, ovf_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    // Slice selection by shifting keeps the index arithmetic width-clean
    // for every legal SLICE_W, including the single-slice case.
    logic [5:0]          base;
    logic [SLICE_W-1:0]  sl_a, sl_b, sl_s;
    logic                sl_co, sl_cmsb;
    logic [DATA_W-1:0]   sl_mask, sl_ins;
    logic                last;

    assign base    = 6'(k_q) * 6'(SLICE_W);
    assign sl_a    = SLICE_W'(a_q >> base);
    assign sl_b    = SLICE_W'(b_q >> base);
    assign sl_mask = DATA_W'({SLICE_W{1'b1}}) << base;
    assign sl_ins  = DATA_W'(sl_s) << base;
    assign last    = (k_q == CNT_W'(N - 1));

    add_slice #(.W(SLICE_W)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .ci    (c_q),
        .s     (sl_s),
        .co    (sl_co),
        .c_msb (sl_cmsb)
    );

    // Next-state and datapath: latch on accept, one slice per RUN cycle.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d = in_a;
                    b_d = in_b;
                    c_d = cin1;
`ifdef ADD32_SEQ_SUB_EN
                    // A - B as A + ~B + 1; cout=1 then means no borrow.
                    if (sub) begin
                        b_d = ~in_b;
                        c_d = 1'b1;
                    end
`endif
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d = (sum_q & ~sl_mask) | sl_ins;
                c_d   = sl_co;
                k_d   = k_q + CNT_W'(1);
                if (last) begin
                    cout_d  = sl_co;
                    ovf_d   = sl_co ^ sl_cmsb;
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Result taken: back to IDLE, no accept in this same cycle.
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            c_q         <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            c_q         <= c_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sout      = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add32_seq_ctrl.sv
// tb_add32_seq_ctrl: directed bench for add32_seq_ctrl with SLICE_W = 8, 1
// and 32 instances; a transaction-level model checks the SLICE_W=8 instance
// every cycle. Honours ADD32_SEQ_SUB_EN when defined.
module tb_add32_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        cin1 = 1'b0;
`ifdef ADD32_SEQ_SUB_EN
    logic        sub = 1'b0;
`endif
    logic        iv   [3];
    logic        ordy [3];
    logic        irdy [3];
    logic        ovld [3];
    logic        co   [3];
    logic        ov   [3];
    logic        bz   [3];
    logic [31:0] so   [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    add32_seq_ctrl #(.SLICE_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_a(in_a), .in_b(in_b), .cin1(cin1),
`ifdef ADD32_SEQ_SUB_EN
        .sub(sub),
`endif
        .out_valid(ovld[0]), .out_ready(ordy[0]), .sout(so[0]),
        .cout(co[0]), .ovf(ov[0]), .busy(bz[0]));

    add32_seq_ctrl #(.SLICE_W(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_a(in_a), .in_b(in_b), .cin1(cin1),
`ifdef ADD32_SEQ_SUB_EN
        .sub(sub),
`endif
        .out_valid(ovld[1]), .out_ready(ordy[1]), .sout(so[1]),
        .cout(co[1]), .ovf(ov[1]), .busy(bz[1]));

    add32_seq_ctrl #(.SLICE_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_a(in_a), .in_b(in_b), .cin1(cin1),
`ifdef ADD32_SEQ_SUB_EN
        .sub(sub),
`endif
        .out_valid(ovld[2]), .out_ready(ordy[2]), .sout(so[2]),
        .cout(co[2]), .ovf(ov[2]), .busy(bz[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Transaction model for the SLICE_W=8 instance: phase 0 idle,
    // 1 computing (result due 4 edges after accept), 2 holding result.
    int          m_ph;
    int          m_left;
    logic [32:0] m_sum;
    logic        m_ovf;
    logic        m_fresh;
    logic [31:0] m_b;
    logic        m_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph    = 0;
            m_left  = 0;
            m_fresh = 1'b1;
        end else begin
            case (m_ph)
                0: if (iv[0]) begin
                    m_b = in_b;
                    m_c = cin1;
`ifdef ADD32_SEQ_SUB_EN
                    if (sub) begin
                        m_b = ~in_b;
                        m_c = 1'b1;
                    end
`endif
                    m_sum   = {1'b0, in_a} + {1'b0, m_b} + 33'(m_c);
                    m_ovf   = (in_a[31] == m_b[31]) && (m_sum[31] != in_a[31]);
                    m_left  = 4;
                    m_ph    = 1;
                    m_fresh = 1'b0;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_ph = 2;
                end
                default: if (ordy[0]) m_ph = 0;
            endcase
        end
    end

    // Compare the SLICE_W=8 instance against the model every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("m_in_ready", 32'(irdy[0]), 32'(m_ph == 0));
            chk("m_out_valid", 32'(ovld[0]), 32'(m_ph == 2));
            chk("m_busy", 32'(bz[0]), 32'(m_ph != 0));
            if (m_ph == 2) begin
                chk("m_sout", so[0], m_sum[31:0]);
                chk("m_cout", 32'(co[0]), 32'(m_sum[32]));
                chk("m_ovf", 32'(ov[0]), 32'(m_ovf));
            end else if (m_fresh) begin
                chk("m_sout_rst", so[0], 32'h0);
                chk("m_cout_rst", 32'(co[0]), 32'h0);
                chk("m_ovf_rst", 32'(ov[0]), 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on instance u with hand-computed expectations.
    task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input int lat, input logic [31:0] es,
                          input logic ec, input logic eo, input string nm);
        int n;
        in_a  = a;
        in_b  = b;
        cin1  = c;
        iv[u] = 1'b1;
        tick();
        iv[u] = 1'b0;
        n = 0;
        while (!ovld[u] && n < 100) begin
            tick();
            n++;
        end
        chk({nm, "_lat"}, n, lat);
        chk({nm, "_sum"}, so[u], es);
        chk({nm, "_cout"}, 32'(co[u]), 32'(ec));
        chk({nm, "_ovf"}, 32'(ov[u]), 32'(eo));
        if (u == 0) chk({nm, "_model"}, m_sum[31:0], es);
        ordy[u] = 1'b1;
        tick();
        ordy[u] = 1'b0;
        chk({nm, "_idle_rdy"}, 32'(irdy[u]), 32'h1);
        chk({nm, "_idle_vld"}, 32'(ovld[u]), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        tick();
        tick();
        // Reset values while rst_n is held low.
        chk("rst_out_valid", 32'(ovld[0]), 32'h0);
        chk("rst_busy", 32'(bz[0]), 32'h0);
        chk("rst_sout", so[0], 32'h0);
        chk("rst_cout", 32'(co[0]), 32'h0);
        chk("rst_ovf", 32'(ov[0]), 32'h0);
        chk("rst_in_ready", 32'(irdy[0]), 32'h1);
        rst_n = 1'b1;
        tick();

        run_op(0, 32'h0000_0001, 32'h0000_0002, 1'b0, 4, 32'h0000_0003, 1'b0, 1'b0, "basic");
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4, 32'h0000_0000, 1'b1, 1'b0, "ripple8");
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4, 32'h8000_0000, 1'b0, 1'b1, "ovf8");
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 4, 32'h0000_0000, 1'b1, 1'b1, "negovf8");
        run_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 4, 32'hACF1_3568, 1'b0, 1'b0, "mix8");
        run_op(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32, 32'h0000_0000, 1'b1, 1'b0, "ripple1");
        run_op(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, 32'h0000_0000, 1'b1, 1'b0, "ripple32");
        run_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32, 32'h8000_0000, 1'b0, 1'b1, "ovf1");
        run_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h8000_0000, 1'b0, 1'b1, "ovf32");

        // Backpressure: result held while inputs wiggle; no same-cycle re-accept.
        begin
            int n;
            in_a = 32'd3;
            in_b = 32'd4;
            cin1 = 1'b0;
            iv[0] = 1'b1;
            tick();
            iv[0] = 1'b0;
            n = 0;
            while (!ovld[0] && n < 100) begin
                tick();
                n++;
            end
            chk("bp_lat", n, 4);
            for (int i = 0; i < 10; i++) begin
                in_a  = $urandom;
                in_b  = $urandom;
                iv[0] = i[0];
                tick();
                chk("bp_sout", so[0], 32'd7);
                chk("bp_in_ready", 32'(irdy[0]), 32'h0);
            end
            iv[0]   = 1'b1;
            ordy[0] = 1'b1;
            tick();
            ordy[0] = 1'b0;
            chk("bp_after_rdy", 32'(irdy[0]), 32'h1);
            chk("bp_no_reaccept", 32'(bz[0]), 32'h0);
            chk("bp_after_vld", 32'(ovld[0]), 32'h0);
            iv[0] = 1'b0;
            tick();
        end

        // Reset in the middle of RUN discards the operation.
        in_a  = 32'hDEAD_BEEF;
        in_b  = 32'h0000_0001;
        cin1  = 1'b0;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_sout", so[0], 32'h0);
        chk("midrst_out_valid", 32'(ovld[0]), 32'h0);
        chk("midrst_busy", 32'(bz[0]), 32'h0);
        chk("midrst_cout", 32'(co[0]), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        run_op(0, 32'd5, 32'd7, 1'b0, 4, 32'd12, 1'b0, 1'b0, "post_rst");

`ifdef ADD32_SEQ_SUB_EN
        sub = 1'b1;
        run_op(0, 32'd5, 32'd7, 1'b0, 4, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub8");
        run_op(0, 32'd7, 32'd5, 1'b0, 4, 32'h0000_0002, 1'b1, 1'b0, "sub8b");
        sub = 1'b0;
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

endmodule

// File: doc/add32_seq_ctrl.md
ADD32_SEQ_CTRL -- requirements
Module: add32_seq_ctrl

Interface
REQ-001 The block SHALL have parameter SLICE_W, default 8: width of the shared adder slice; legal values 1, 2, 4, 8, 16, 32.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port in_valid, input, 1: operands and carry-in offered.
REQ-005 The block SHALL have port in_ready, output, 1: block can accept operands.
REQ-006 The block SHALL have port in_a, input, 32: operand A.
REQ-007 The block SHALL have port in_b, input, 32: operand B.
REQ-008 The block SHALL have port cin1, input, 1: carry-in.
REQ-009 The block SHALL have port out_valid, output, 1: result held on the outputs.
REQ-010 The block SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 The block SHALL have port sout, output, 32: sum.
REQ-012 The block SHALL have port cout, output, 1: carry out of bit 31.
REQ-013 The block SHALL have port ovf, output, 1: signed overflow, i.e. carry into bit 31 XOR carry out of bit 31.
REQ-014 The block SHALL have port busy, output, 1: high in RUN or DONE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 The block SHALL drive in_ready=1 only in IDLE.
- Accept = in_valid & in_ready.
- On accept: latch in_a, in_b and cin1; clear slice counter; go to RUN.
REQ-017 In RUN, each cycle SHALL add slice k (bits k*SLICE_W +: SLICE_W) with the registered carry.
- Write the slice sum into the result register.
- Register the slice carry-out; increment k.
REQ-018 After slice N-1 (N = 32/SLICE_W), the FSM SHALL go to DONE.
- out_valid rises exactly N cycles after the accept edge.
- For SLICE_W=32, N=1.
REQ-019 In DONE, out_valid=1 and sout/cout/ovf SHALL hold stable until out_ready=1.
- On the out_valid & out_ready edge: go to IDLE; out_valid=0 next cycle.
REQ-020 The block SHALL NOT accept new operands in the same cycle the result is taken; earliest re-accept is the following cycle.
REQ-021 Input changes during RUN/DONE SHALL have no effect on the result.
REQ-022 The addition SHALL be modulo 2^32.
- cout and ovf are taken from the final slice.
- For the final slice with SLICE_W=1, the carry into bit 31 is the registered carry.

Reset
REQ-023 On rst_n=0, asynchronously:
- state=IDLE, counter=0.
- in_ready=1 (once out of reset), out_valid=0, busy=0.
- sout=0, cout=0, ovf=0.
REQ-024 Reset mid-RUN or mid-DONE SHALL discard the operation; no out_valid is produced for it.

Configuration
REQ-025 Macro ADD32_SEQ_SUB_EN SHALL control subtraction support.
- Defined: an extra input port sub (1 bit) is latched on accept. When sub=1, operand B is inverted and carry-in forced to 1 (A-B); cout=1 means no borrow.
- Undefined: the sub port is absent; the block only adds.

Structure
REQ-026 Package add32_pkg SHALL hold DATA_W=32 and the state enum typedef (IDLE/RUN/DONE).
REQ-027 One sub-module add_slice SHALL be used.
- Combinational SLICE_W-bit ripple adder built from fulladder cells.
- Outputs: slice sum, slice carry-out, carry into the slice MSB.

Verification
REQ-028 Basic add, SLICE_W=8: A=0x0000_0001, B=0x0000_0002, cin1=0 -> out_valid 4 cycles after accept; sout=0x0000_0003, cout=0, ovf=0.
REQ-029 Full carry ripple: A=0xFFFF_FFFF, B=0x0000_0000, cin1=1 -> sout=0x0000_0000, cout=1, ovf=0; same result with SLICE_W=1 after 32 cycles and SLICE_W=32 after 1 cycle.
REQ-030 Signed overflow: A=0x7FFF_FFFF, B=0x0000_0001, cin1=0 -> sout=0x8000_0000, cout=0, ovf=1.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles and toggle in_a/in_valid meanwhile -> sout stable, in_ready=0 throughout; on out_ready=1, IDLE next cycle.
REQ-032 Reset mid-RUN: deassert rst_n after slice 2 -> outputs zero immediately; no out_valid; next op A=5, B=7 gives sout=12.
REQ-033 With ADD32_SEQ_SUB_EN defined: A=5, B=7, sub=1 -> sout=0xFFFF_FFFE, cout=0.
